mc_exec_unit: RTL
=================

Name: mc_exec_unit

Overview:
- Multi-cycle execute/writeback engine downstream of the fetch+decode controller.
- Consumes a fetched instruction plus the decoded control bundle: regwrite, regdst, alusrc, branch, memWrite, memtoReg, alucontroll.
- Owns the 32x32 register file and the ALU, drives the data-memory port, and returns branch resolution (pcsrc, branch_target) to the PC logic.
- Accepts one instruction at a time through a valid/ready handshake.

Parameters:
- DW, 32, datapath and register width.
- NREG, 32, register count (5-bit register addresses).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction and control bundle valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- instr  in  32  instruction word.
- pc_plus4  in  32  address of instruction + 4.
- regwrite, regdst, alusrc, branch, memWrite, memtoReg  in  1 each  decoded controls.
- alucontroll  in  3  ALU operation code.
- dmem_en  out  1  data-memory request.
- dmem_we  out  1  write strobe, qualified by dmem_en.
- dmem_addr  out  32  ALU result.
- dmem_wdata  out  32  rt operand.
- dmem_rdata  in  32  read data, valid when dmem_ack=1.
- dmem_ack  in  1  memory completion, one-cycle pulse.
- done  out  1  one-cycle retire pulse.
- pcsrc  out  1  branch taken; valid with done.
- branch_target  out  32  pc_plus4 + (sign-extended imm << 2); valid with done.
- wb_en, wb_addr[4:0], wb_data[31:0]  out  register-file write port, observable for checking.

Behaviour:
- Reset: state IDLE, all 32 registers = 0, in_ready=1. done, pcsrc, dmem_en, dmem_we, wb_en = 0. Addr/data outputs = 0.
- An active reset in any state aborts the instruction: no register write, dmem_en drops on the next edge.
- Handshake: accept when in_valid && in_ready. Accepting latches instr, pc_plus4 and all controls; later changes on the inputs are ignored.
- FSM:
  - IDLE -> DECODE on accept.
  - DECODE: A <= R[instr[25:21]], B <= R[instr[20:16]], imm <= sign-extended instr[15:0]. -> EXEC.
  - EXEC: Y <= ALU(A, alusrc ? imm : B); zero <= (A - B) == 0. -> MEM if memWrite|memtoReg, else WB.
  - MEM: dmem_en=1, dmem_we=memWrite, held stable until dmem_ack. On ack, capture dmem_rdata into M. -> WB.
  - WB: done=1. If regwrite: wb_en=1, wb_addr = regdst ? instr[15:11] : instr[20:16], wb_data = memtoReg ? M : Y, register written at end of cycle. -> IDLE.
- Latency, accept to done: 3 cycles without memory; 4 + (ack wait) cycles with memory.
- ALU codes:
  - 010 add, 110 sub, 000 and, 001 or.
  - 111 slt (signed, result 1/0).
  - Any other code -> 0.
  - Arithmetic is 32-bit and wraps; no overflow trap.
- Register 0 always reads 0; a write to register 0 pulses wb_en but leaves the register unchanged.
- pcsrc = latched branch & zero, driven only during done, 0 otherwise. branch_target is computed in EXEC.
- The all-zero control bundle (jump, unsupported opcodes) retires as a no-op with pcsrc=0. Jumps are resolved by fetch.
- An instruction that reads a register written by the previous one sees the new value, since the write completes before the next DECODE.

Decomposition:
- Shared package holds:
  - ALU code constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
  - FSM state encoding: IDLE, DECODE, EXEC, MEM, WB.
  - Opcode constants matching the decoder.
- One natural sub-module: mc_regfile, 2 async read ports, 1 sync write port, synchronous reset, register 0 hardwired.
- ALU stays inline.

Test Plan:
1. addi $1,$0,5 (0x20010005; regwrite, alusrc, alucontroll=010) -> done 3 cycles after accept; wb_en=1, wb_addr=1, wb_data=5.
2. With $1=5 and $2=7, add $3,$1,$2 then slt $4,$2,$1 -> $3=12 and $4=0. Then sub $5,$1,$2 -> $5=0xFFFFFFFE.
3. sw $3,8($0) with dmem_ack delayed 3 cycles -> dmem_en/we held with addr=8, wdata=12 until ack; done with wb_en=0. Then lw $6,8($0) with rdata=12 -> $6=12.
4. beq $1,$1,-2 with pc_plus4=0x40 -> done with pcsrc=1, branch_target=0x38. beq $1,$2 -> pcsrc=0.
5. addi $0,$0,9 -> register 0 reads 0 afterward. in_valid held high during a busy interval -> in_ready=0 and no second accept until IDLE.
6. reset asserted during MEM -> next cycle state IDLE, dmem_en=0, no write-back, all registers read 0.

Source files
------------

// File: rtl/mc_exec_unit_pkg.sv
// Shared definitions for the multi-cycle execute/writeback unit:
// ALU codes, FSM states, decoder opcodes and the latched control bundle.
package mc_exec_unit_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  // Opcodes as produced by the upstream decoder.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic       branch;
    logic       mem_write;
    logic       mem_to_reg;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// synchronous reset, register 0 hardwired to zero.
module mc_regfile #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] rf [NREG];

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign rf[gi] = '0;
    end else begin : g_live
      logic [DW-1:0] q_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          q_reg <= wdata;
        end
      end
      assign rf[gi] = q_reg;
    end
  end

  assign rdata_a = rf[raddr_a];
  assign rdata_b = rf[raddr_b];

endmodule

// File: rtl/mc_exec_unit.sv
// Multi-cycle execute/writeback engine: latches one decoded instruction,
// walks DECODE/EXEC/MEM/WB, owns the register file and resolves branches.
module mc_exec_unit
  import mc_exec_unit_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] pc_plus4,
  input  logic          regwrite,
  input  logic          regdst,
  input  logic          alusrc,
  input  logic          branch,
  input  logic          memWrite,
  input  logic          memtoReg,
  input  logic [2:0]    alucontroll,
  output logic          dmem_en,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          done,
  output logic          pcsrc,
  output logic [DW-1:0] branch_target,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data
);

  state_t        state_reg, state_next;
  logic [31:0]   instr_reg;
  logic [DW-1:0] pc4_reg, a_reg, b_reg, imm_reg, y_reg, m_reg, target_reg;
  logic          zero_reg;
  ctrl_t         ctrl_reg;
  logic [DW-1:0] rd_a, rd_b, alu_b, alu_y, imm_ext;
  logic          unused_opcode;

  assign unused_opcode = ^instr_reg[31:26];
  assign imm_ext       = {{(DW-16){instr_reg[15]}}, instr_reg[15:0]};

  mc_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .rst     (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (AW'(instr_reg[25:21])),
    .raddr_b (AW'(instr_reg[20:16])),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  always_comb begin
    alu_b = ctrl_reg.alusrc ? imm_reg : b_reg;
    case (ctrl_reg.alu_op)
      ALU_ADD: alu_y = a_reg + alu_b;
      ALU_SUB: alu_y = a_reg - alu_b;
      ALU_AND: alu_y = a_reg & alu_b;
      ALU_OR:  alu_y = a_reg | alu_b;
      ALU_SLT: alu_y = {{(DW-1){1'b0}}, ($signed(a_reg) < $signed(alu_b))};
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      instr_reg  <= '0;
      pc4_reg    <= '0;
      ctrl_reg   <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      imm_reg    <= '0;
      y_reg      <= '0;
      m_reg      <= '0;
      target_reg <= '0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (in_valid) begin
          instr_reg <= instr;
          pc4_reg   <= pc_plus4;
          ctrl_reg  <= '{regwrite, regdst, alusrc, branch, memWrite, memtoReg, alucontroll};
        end
        DECODE: begin
          a_reg   <= rd_a;
          b_reg   <= rd_b;
          imm_reg <= imm_ext;
        end
        EXEC: begin
          y_reg      <= alu_y;
          zero_reg   <= ((a_reg - b_reg) == '0);
          target_reg <= pc4_reg + (imm_reg << 2);
        end
        MEM: if (dmem_ack) m_reg <= dmem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = (ctrl_reg.mem_write | ctrl_reg.mem_to_reg) ? MEM : WB;
      MEM:     if (dmem_ack) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    dmem_en  = 1'b0;
    dmem_we  = 1'b0;
    pcsrc    = 1'b0;
    wb_en    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    case (state_reg)
      IDLE: in_ready = 1'b1;
      MEM: begin
        dmem_en = 1'b1;
        dmem_we = ctrl_reg.mem_write;
      end
      WB: begin
        done  = 1'b1;
        pcsrc = ctrl_reg.branch & zero_reg;
        if (ctrl_reg.regwrite) begin
          wb_en   = 1'b1;
          wb_addr = ctrl_reg.regdst ? AW'(instr_reg[15:11]) : AW'(instr_reg[20:16]);
          wb_data = ctrl_reg.mem_to_reg ? m_reg : y_reg;
        end
      end
      default: ;
    endcase
  end

  assign dmem_addr     = y_reg;
  assign dmem_wdata    = b_reg;
  assign branch_target = target_reg;

endmodule
